inst_sequencer: RTL and testbench
=================================

Name: inst_sequencer

Overview:
- Parametrised successor to the single-instruction decoder stage control.
- Buffers fetched instructions in a small queue and classifies each one.
- Steps each instruction through up to three decode stages (PRE push-pc, IMM16 wait, MAIN), handshaking each stage with the scheduler.
- Sits between prefetch and decoder/scheduler; replaces the hard-wired one-bit stage register with an explicit FSM and queue.

Parameters:
- INST_BITS, 16, instruction width.
- IQ_DEPTH, 2, instruction queue entries (>=1).
- NSHIFT, 2, width of plus_pc_words (serial datapath width).
- CALL_CC, 4'hE, condition code that makes a branch a call.
- TIMEOUT_CYCLES, 255, stage watchdog limit (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- inst_in_valid  in  1  instruction offered by prefetch.
- inst_in  in  INST_BITS  instruction word.
- inst_in_ready  out  1  queue can accept; accepted when valid&&ready at clk edge.
- flush  in  1  discard all queued, not-yet-started instructions.
- imm16_request  out  1  ask prefetch to load imm16.
- imm16_loaded  in  1  imm16 available.
- stage_valid  out  1  a PRE or MAIN stage is presented.
- stage_pre  out  1  1 = PRE (push pc+n) stage, 0 = MAIN.
- stage_inst  out  INST_BITS  current instruction.
- plus_pc_words  out  NSHIFT  words to add to pc for push (1 or 2).
- stage_done  in  1  scheduler finished presented stage.
- inst_done  out  1  one-cycle pulse when MAIN completes.
- iq_count  out  $clog2(IQ_DEPTH+1)  queue occupancy.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset values: all outputs 0, queue empty, FSM IDLE, stage_inst 0. Reset asserted mid-instruction aborts it: no inst_done, queue emptied.
- Classification (combinational on the instruction being loaded; registered with it):
  - branch = inst[15:12]==0.
  - need_pre = (branch && inst[11:8]==CALL_CC) || inst[15:6]==10'b0010000001.
  - long = !branch && inst[5:2]==0 && inst[0]==1.
  - plus_pc_words = long ? 2 : 1, zero-extended to NSHIFT.
- Queue:
  - FIFO with wrapping pointers.
  - inst_in_ready = !full. No push when full, even if a pop occurs in the same cycle.
  - No bypass: a push to an empty queue is first visible next cycle.
- Pop loads cur, the head of the queue, and selects the first state: PRE if need_pre, else IMM if long, else MAIN.
- FSM states IDLE, PRE, IMM, MAIN:
  - IDLE: pop when non-empty, otherwise stay.
  - PRE: stage_valid=1, stage_pre=1. On stage_done: go to IMM if long, else MAIN.
  - IMM: stage_valid=0, imm16_request=1. On imm16_loaded: go to MAIN. If imm16_loaded is already high on entry, leave after one cycle.
  - MAIN: stage_valid=1, stage_pre=0. On stage_done: pulse inst_done next cycle, then pop the next instruction in the same edge if the queue is non-empty (back-to-back), else go to IDLE.
- Latency: an instruction accepted at edge E0 into an empty queue with FSM IDLE is popped at E1; stage_valid is high in the cycle after E1.
- stage_inst and plus_pc_words stay stable from pop until the next pop.
- flush:
  - Empties the queue at the clock edge and wins over a simultaneous push (that push is dropped).
  - Does not affect cur or the FSM; the current instruction (typically the jump) completes normally.
  - A pop and a flush in the same cycle: the pop still loads cur, then the queue is emptied.
- stage_done outside PRE/MAIN is ignored. imm16_loaded outside IMM is ignored.
- iq_count is the registered occupancy after the edge.

Optional Feature:
- Macro: INST_SEQUENCER_TIMEOUT_EN.
- With the macro:
  - A counter clears on every state entry and increments each cycle in PRE, IMM or MAIN.
  - When it reaches TIMEOUT_CYCLES without leaving the state, timeout_err is set.
  - timeout_err is sticky until reset; the FSM keeps waiting.
- Without the macro: no counter; timeout_err is tied to 0.

Test Plan:
- Push 0x8040 into an empty queue at E0 -> stage_valid=1, stage_pre=0 after E1. Assert stage_done one cycle -> inst_done pulses once, FSM returns to IDLE, iq_count=0.
- Push 0x0E10 (branch, cc=E, call) -> PRE with plus_pc_words=1, no imm16_request. stage_done -> MAIN. stage_done -> inst_done.
- Push 0x2041 (call src, imm16) -> PRE with plus_pc_words=2. stage_done -> imm16_request=1. Hold imm16_loaded=0 for 5 cycles, then pulse it -> MAIN.
- Push 3 words with IQ_DEPTH=2 while MAIN is stalled -> the third is refused (inst_in_ready=0, iq_count=2). Release -> the two queued words run back-to-back with no IDLE cycle between them.
- Queue 2 words, assert flush together with a push during MAIN -> iq_count=0, current MAIN completes with inst_done, FSM then goes to IDLE.
- Assert reset in PRE -> all outputs 0 immediately (asynchronous). With the macro and TIMEOUT_CYCLES=4, hold MAIN without stage_done -> timeout_err=1 after 4 cycles and remains set.

Source files
------------

// File: rtl/inst_sequencer.sv
// inst_sequencer: buffers fetched instructions in a small FIFO, classifies
// each one as it is popped, and steps it through up to three decode stages
// (PRE push-pc, IMM16 wait, MAIN), handshaking each stage with the scheduler.
//
// Optional build macro: INST_SEQUENCER_TIMEOUT_EN enables a per-stage
// watchdog that sets the sticky timeout_err output. When the macro is not
// defined, timeout_err is tied to 0.

module inst_sequencer #(
  parameter int          INST_BITS      = 16,
  parameter int          IQ_DEPTH       = 2,
  parameter int          NSHIFT         = 2,
  parameter logic [3:0]  CALL_CC        = 4'hE,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            inst_in_valid,
  input  logic [INST_BITS-1:0]            inst_in,
  output logic                            inst_in_ready,
  input  logic                            flush,
  output logic                            imm16_request,
  input  logic                            imm16_loaded,
  output logic                            stage_valid,
  output logic                            stage_pre,
  output logic [INST_BITS-1:0]            stage_inst,
  output logic [NSHIFT-1:0]               plus_pc_words,
  input  logic                            stage_done,
  output logic                            inst_done,
  output logic [$clog2(IQ_DEPTH+1)-1:0]   iq_count,
  output logic                            timeout_err
);

  localparam int CNT_W = $clog2(IQ_DEPTH + 1);
  localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_IMM  = 2'd2,
    ST_MAIN = 2'd3
  } state_t;

  // Decode attributes that decide which stages an instruction visits.
  typedef struct packed {
    logic need_pre;  // push pc+n before the main stage (calls)
    logic is_long;   // carries an imm16 extension word
  } inst_class_t;

  // Classification looks only at the low 16 bits of the instruction word.
  function automatic inst_class_t classify(input logic [15:0] w);
    inst_class_t c;
    logic        branch;
    branch     = (w[15:12] == 4'h0);
    c.need_pre = (branch && (w[11:8] == CALL_CC)) || (w[15:6] == 10'b0010000001);
    c.is_long  = !branch && (w[5:2] == 4'h0) && w[0];
    return c;
  endfunction

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(IQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  logic [INST_BITS-1:0] iq_mem [IQ_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 empty;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic [INST_BITS-1:0] head;
  inst_class_t          head_class;

  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(IQ_DEPTH));
  // Flush drops any word offered in the same cycle.
  assign push       = inst_in_valid && !full && !flush;
  assign head       = iq_mem[rd_ptr];
  assign head_class = classify(head[15:0]);

  // Readiness is held low while reset is asserted so every output reads 0.
  assign inst_in_ready = !full && !reset;
  assign iq_count      = count;

  // Queue storage: write the offered word at the tail.
  // NOTE: the storage array has no reset; only the pointers and count are
  // reset, which is enough to make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      iq_mem[wr_ptr] <= inst_in;
    end
  end

  // Queue pointers and occupancy; flush empties the queue after any pop
  // in the same cycle has already sampled the head.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage sequencer
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_next;
  logic   done_next;
  logic   cur_long;

  // Next-state logic: decides pops, stage transitions and completion.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
        end
      end
      ST_PRE: begin
        if (stage_done) begin
          state_next = cur_long ? ST_IMM : ST_MAIN;
        end
      end
      ST_IMM: begin
        if (imm16_loaded) begin
          state_next = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (stage_done) begin
          done_next = 1'b1;
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // A pop picks the first stage the new instruction needs.
    if (pop) begin
      if (head_class.need_pre) begin
        state_next = ST_PRE;
      end else if (head_class.is_long) begin
        state_next = ST_IMM;
      end else begin
        state_next = ST_MAIN;
      end
    end
  end

  // State register and the registered completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      inst_done <= 1'b0;
    end else begin
      state     <= state_next;
      inst_done <= done_next;
    end
  end

  // Current-instruction register: loaded on pop, stable until the next pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_inst    <= '0;
      cur_long      <= 1'b0;
      plus_pc_words <= '0;
    end else if (pop) begin
      stage_inst    <= head;
      cur_long      <= head_class.is_long;
      plus_pc_words <= head_class.is_long ? NSHIFT'(2) : NSHIFT'(1);
    end
  end

  assign stage_valid   = (state == ST_PRE) || (state == ST_MAIN);
  assign stage_pre     = (state == ST_PRE);
  assign imm16_request = (state == ST_IMM);

  // ---------------------------------------------------------------------------
  // Stage watchdog
  // ---------------------------------------------------------------------------
`ifdef INST_SEQUENCER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_err;
  logic            state_entry;
  logic            busy;

  // A pop from MAIN back into MAIN is a fresh entry as well.
  assign state_entry = (state_next != state) || pop;
  assign busy        = (state != ST_IDLE);

  // Count cycles spent in one stage; flag once the limit is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (state_entry) begin
      to_cnt <= '0;
    end else if (busy && (to_cnt != TO_W'(TIMEOUT_CYCLES))) begin
      to_cnt <= to_cnt + 1'b1;
      if ((to_cnt + 1'b1) == TO_W'(TIMEOUT_CYCLES)) begin
        to_err <= 1'b1;
      end
    end
  end

  assign timeout_err = to_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed self-checking bench for inst_sequencer (IQ_DEPTH=2, watchdog
// limit 4 so the optional timeout path is short when it is compiled in).

module tb_inst_sequencer;

  localparam int INST_BITS = 16;
  localparam int IQ_DEPTH  = 2;
  localparam int NSHIFT    = 2;
  localparam int CNT_W     = $clog2(IQ_DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 inst_in_valid;
  logic [INST_BITS-1:0] inst_in;
  logic                 inst_in_ready;
  logic                 flush;
  logic                 imm16_request;
  logic                 imm16_loaded;
  logic                 stage_valid;
  logic                 stage_pre;
  logic [INST_BITS-1:0] stage_inst;
  logic [NSHIFT-1:0]    plus_pc_words;
  logic                 stage_done;
  logic                 inst_done;
  logic [CNT_W-1:0]     iq_count;
  logic                 timeout_err;

  int total = 0;
  int bad   = 0;

  inst_sequencer #(
    .INST_BITS      (INST_BITS),
    .IQ_DEPTH       (IQ_DEPTH),
    .NSHIFT         (NSHIFT),
    .CALL_CC        (4'hE),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inst_in_valid (inst_in_valid),
    .inst_in       (inst_in),
    .inst_in_ready (inst_in_ready),
    .flush         (flush),
    .imm16_request (imm16_request),
    .imm16_loaded  (imm16_loaded),
    .stage_valid   (stage_valid),
    .stage_pre     (stage_pre),
    .stage_inst    (stage_inst),
    .plus_pc_words (plus_pc_words),
    .stage_done    (stage_done),
    .inst_done     (inst_done),
    .iq_count      (iq_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] W0 = 16'h8040;  // plain MAIN-only
  localparam logic [15:0] W1 = 16'h1000;  // plain MAIN-only
  localparam logic [15:0] W2 = 16'h3004;  // plain MAIN-only
  localparam logic [15:0] W3 = 16'h4008;  // plain MAIN-only
  localparam logic [15:0] CALL_BR  = 16'h0E10;  // branch cc=E: PRE, short
  localparam logic [15:0] CALL_IMM = 16'h2041;  // call src, long: PRE, IMM

  initial begin
    reset         = 1'b1;
    inst_in_valid = 1'b0;
    inst_in       = '0;
    flush         = 1'b0;
    imm16_loaded  = 1'b0;
    stage_done    = 1'b0;
    #1;
    // Reset state: every output low.
    check("rst_stage_valid", 32'(stage_valid), 32'd0);
    check("rst_ready",       32'(inst_in_ready), 32'd0);
    check("rst_iq_count",    32'(iq_count), 32'd0);
    check("rst_inst_done",   32'(inst_done), 32'd0);
    check("rst_stage_inst",  32'(stage_inst), 32'd0);
    check("rst_plus_pc",     32'(plus_pc_words), 32'd0);
    check("rst_imm16_req",   32'(imm16_request), 32'd0);
    check("rst_timeout",     32'(timeout_err), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_ready", 32'(inst_in_ready), 32'd1);

    // 1: simple MAIN-only instruction, latency and completion.
    inst_in_valid = 1'b1;
    inst_in       = W0;
    tick();                                   // E0: push
    inst_in_valid = 1'b0;
    check("t1_no_bypass_valid", 32'(stage_valid), 32'd0);
    check("t1_count_after_push", 32'(iq_count), 32'd1);
    tick();                                   // E1: pop
    check("t1_stage_valid", 32'(stage_valid), 32'd1);
    check("t1_stage_pre",   32'(stage_pre), 32'd0);
    check("t1_stage_inst",  32'(stage_inst), 32'(W0));
    check("t1_plus_pc",     32'(plus_pc_words), 32'd1);
    check("t1_count_popped", 32'(iq_count), 32'd0);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("t1_inst_done",   32'(inst_done), 32'd1);
    check("t1_back_idle",   32'(stage_valid), 32'd0);
    tick();
    check("t1_done_pulse_end", 32'(inst_done), 32'd0);
    check("t1_count_end",   32'(iq_count), 32'd0);

    // 2: call branch -> PRE (plus 1) -> MAIN.
    inst_in_valid = 1'b1;
    inst_in       = CALL_BR;
    tick();
    inst_in_valid = 1'b0;
    tick();
    check("t2_pre_valid", 32'(stage_valid), 32'd1);
    check("t2_pre_flag",  32'(stage_pre), 32'd1);
    check("t2_plus_pc",   32'(plus_pc_words), 32'd1);
    check("t2_no_imm_req", 32'(imm16_request), 32'd0);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("t2_main_valid", 32'(stage_valid), 32'd1);
    check("t2_main_pre",   32'(stage_pre), 32'd0);
    check("t2_no_done_yet", 32'(inst_done), 32'd0);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("t2_inst_done", 32'(inst_done), 32'd1);
    tick();

    // 3: call src with imm16 -> PRE (plus 2) -> IMM (wait) -> MAIN.
    inst_in_valid = 1'b1;
    inst_in       = CALL_IMM;
    tick();
    inst_in_valid = 1'b0;
    tick();
    check("t3_pre_flag", 32'(stage_pre), 32'd1);
    check("t3_plus_pc",  32'(plus_pc_words), 32'd2);
    stage_done = 1'b1;
    tick();
    check("t3_imm_req",   32'(imm16_request), 32'd1);
    check("t3_imm_valid", 32'(stage_valid), 32'd0);
    // stage_done stays high for the first IMM cycle and must be ignored.
    for (int i = 0; i < 5; i++) begin
      tick();
      stage_done = 1'b0;
    end
    check("t3_imm_still_wait", 32'(imm16_request), 32'd1);
    check("t3_imm_no_done",    32'(inst_done), 32'd0);
    imm16_loaded = 1'b1;
    tick();
    imm16_loaded = 1'b0;
    check("t3_main_valid", 32'(stage_valid), 32'd1);
    check("t3_main_pre",   32'(stage_pre), 32'd0);
    check("t3_imm_req_off", 32'(imm16_request), 32'd0);
    check("t3_plus_stable", 32'(plus_pc_words), 32'd2);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("t3_inst_done", 32'(inst_done), 32'd1);
    tick();

    // 4: fill queue while MAIN stalls; third word refused; back-to-back run.
    inst_in_valid = 1'b1;
    inst_in       = W0;
    tick();                                   // push W0
    inst_in       = W1;
    tick();                                   // pop W0, push W1
    inst_in       = W2;
    tick();                                   // push W2
    check("t4_full_count", 32'(iq_count), 32'd2);
    check("t4_not_ready",  32'(inst_in_ready), 32'd0);
    inst_in       = W3;
    tick();                                   // W3 refused
    inst_in_valid = 1'b0;
    check("t4_refused_count", 32'(iq_count), 32'd2);
    check("t4_cur_w0", 32'(stage_inst), 32'(W0));
    stage_done = 1'b1;
    tick();                                   // finish W0, pop W1
    check("t4_done_w0",   32'(inst_done), 32'd1);
    check("t4_b2b_valid1", 32'(stage_valid), 32'd1);
    check("t4_cur_w1",    32'(stage_inst), 32'(W1));
    check("t4_count1",    32'(iq_count), 32'd1);
    check("t4_ready_again", 32'(inst_in_ready), 32'd1);
    tick();                                   // finish W1, pop W2
    check("t4_done_w1",   32'(inst_done), 32'd1);
    check("t4_b2b_valid2", 32'(stage_valid), 32'd1);
    check("t4_cur_w2",    32'(stage_inst), 32'(W2));
    check("t4_count0",    32'(iq_count), 32'd0);
    tick();                                   // finish W2, to IDLE
    stage_done = 1'b0;
    check("t4_done_w2",  32'(inst_done), 32'd1);
    check("t4_idle",     32'(stage_valid), 32'd0);
    tick();
    check("t4_done_off", 32'(inst_done), 32'd0);
    check("t4_w3_dropped", 32'(stage_valid), 32'd0);

    // 5: flush with simultaneous push during MAIN.
    inst_in_valid = 1'b1;
    inst_in       = W0;
    tick();
    inst_in       = W1;
    tick();
    inst_in       = W2;
    tick();
    check("t5_full_before_flush", 32'(iq_count), 32'd2);
    inst_in       = W3;
    flush         = 1'b1;
    tick();
    flush         = 1'b0;
    inst_in_valid = 1'b0;
    check("t5_flushed_count", 32'(iq_count), 32'd0);
    check("t5_cur_kept",      32'(stage_inst), 32'(W0));
    check("t5_main_kept",     32'(stage_valid), 32'd1);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("t5_inst_done", 32'(inst_done), 32'd1);
    check("t5_idle",      32'(stage_valid), 32'd0);
    tick();
    check("t5_stay_idle", 32'(stage_valid), 32'd0);

    // 5b: pop and flush in the same cycle; the pop still loads cur.
    inst_in_valid = 1'b1;
    inst_in       = W1;
    tick();                                   // push W1
    inst_in       = W2;
    flush         = 1'b1;
    tick();                                   // pop W1 + flush, W2 dropped
    flush         = 1'b0;
    inst_in_valid = 1'b0;
    check("t5b_cur_w1",  32'(stage_inst), 32'(W1));
    check("t5b_valid",   32'(stage_valid), 32'd1);
    check("t5b_count",   32'(iq_count), 32'd0);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("t5b_done", 32'(inst_done), 32'd1);
    tick();
    check("t5b_idle", 32'(stage_valid), 32'd0);

    // 6: asynchronous reset in PRE with a queued word.
    inst_in_valid = 1'b1;
    inst_in       = CALL_BR;
    tick();
    inst_in       = W1;
    tick();                                   // pop call, push W1
    inst_in_valid = 1'b0;
    check("t6_in_pre",  32'(stage_pre), 32'd1);
    check("t6_queued",  32'(iq_count), 32'd1);
    reset = 1'b1;
    #2;
    check("t6_rst_valid",  32'(stage_valid), 32'd0);
    check("t6_rst_pre",    32'(stage_pre), 32'd0);
    check("t6_rst_inst",   32'(stage_inst), 32'd0);
    check("t6_rst_plus",   32'(plus_pc_words), 32'd0);
    check("t6_rst_count",  32'(iq_count), 32'd0);
    check("t6_rst_ready",  32'(inst_in_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_no_done",  32'(inst_done), 32'd0);
    check("t6_idle",     32'(stage_valid), 32'd0);

    // 7: watchdog while MAIN is held without stage_done.
    inst_in_valid = 1'b1;
    inst_in       = W0;
    tick();
    inst_in_valid = 1'b0;
    tick();                                   // enter MAIN
    check("t7_main", 32'(stage_valid), 32'd1);
`ifdef INST_SEQUENCER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    check("t7_no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    check("t7_err_set", 32'(timeout_err), 32'd1);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("t7_done_after_err", 32'(inst_done), 32'd1);
    tick();
    check("t7_err_sticky", 32'(timeout_err), 32'd1);
`else
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    check("t7_err_tied_low", 32'(timeout_err), 32'd0);
    check("t7_still_main",   32'(stage_valid), 32'd1);
    stage_done = 1'b1;
    tick();
    stage_done = 1'b0;
    check("t7_done", 32'(inst_done), 32'd1);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
